// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - shared types, widths and bounds helper for ram_master
package ram_master_pkg;

    localparam int LEN_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_RSP
    } state_e;

    // True when a burst starting at addr with len+1 beats would run past the
    // last RAM word instead of staying inside the array.
    function automatic logic bounds_violation(input int unsigned addr,
                                              input int unsigned len,
                                              input int unsigned aw);
        return (addr + len) > ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/ram_master.sv
// rtl/ram_master.sv - burst read/write initiator for a single-port synchronous RAM
//
// Build option: RAM_MASTER_BOUNDS_EN rejects bursts that would run past the
// top of the RAM (req_err pulse, no access); otherwise addresses wrap.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req_valid/ready/we/addr/len  burst command channel (len = beats - 1)
//   wr_valid/ready/data          write beat stream
//   rsp_valid/ready/data/last    read beat stream
//   req_err                      one-cycle rejected-request pulse
//   busy                         burst in progress
//   ram_we/addr/din, ram_dout    RAM pins
module ram_master
    import ram_master_pkg::*;
#(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_last,
    output logic             req_err,
    output logic             busy,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;
    logic             rsp_last_q, rsp_last_d;
    logic             err_q, err_d;
    logic             oob;

`ifdef RAM_MASTER_BOUNDS_EN
    assign oob = bounds_violation(32'(req_addr), 32'(req_len), AW);
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        err_d       = 1'b0;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_din     = '0;
        case (state_q)
            IDLE: begin
                // Held low in reset so nothing is accepted while rst_n is low.
                req_ready = rst_n;
                if (req_valid) begin
                    if (oob) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        cnt_d   = req_len;
                        state_d = req_we ? WR : RD_ISSUE;
                    end
                end
            end
            WR: begin
                // The RAM write and the beat handshake share one edge.
                wr_ready = rst_n;
                ram_we   = wr_valid & rst_n;
                ram_din  = wr_data;
                if (wr_valid) begin
                    addr_d = addr_q + AW'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            RD_ISSUE: begin
                wait_d  = WCW'(RD_LAT - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    rsp_data_d  = ram_dout;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (cnt_q == '0);
                    state_d     = RD_RSP;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            RD_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr  = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign req_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master with a behavioural RAM
module tb_ram_master;

    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic          req_err, busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_wr[$];
    logic [8:0]  exp_rd[$];

    always #5 clk = ~clk;

    ram_master #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .req_err(req_err), .busy(busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    logic [DW-1:0] mem  [1 << AW];
    logic [DW-1:0] pipe [RD_LAT];

    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout = pipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every RAM write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_ram_write", {20'd0, ram_addr, ram_din}, 32'hFFFF_FFFF);
            end else begin
                logic [11:0] e;
                e = exp_wr.pop_front();
                check("ram_write", {20'd0, ram_addr, ram_din}, {20'd0, e});
            end
        end
    end

    // Read monitor: every response handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_rsp", {23'd0, rsp_last, rsp_data}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = exp_rd.pop_front();
                check("rsp_beat", {23'd0, rsp_last, rsp_data}, {23'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [3:0] l);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        if (busy) check("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic write_beat(input logic [DW-1:0] d, input bit stall);
        int n = 0;
        if (stall) begin wr_valid = 1'b0; tick(); end
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && n < 20) begin tick(); n++; end
        if (!wr_ready) check("wr_ready_timeout", 0, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_rd(input logic [DW-1:0] d, input logic last);
        exp_rd.push_back({last, d});
    endtask

    initial begin
        int n;
        logic [7:0] wdat [4];
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;

        // Reset with a pending request
        tick(); tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_req_err", req_err, 0);
        rst_n = 1'b1; req_valid = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1);

        // Single write then read at address 4
        push_wr(4'd4, 8'hA5);
        issue(1'b1, 4'd4, 4'd0);
        write_beat(8'hA5, 1'b0);
        wait_idle();
        check("mem4_after_write", mem[4], 8'hA5);
        push_rd(8'hA5, 1'b1);
        issue(1'b0, 4'd4, 4'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check("rd_latency", n, RD_LAT + 1);
        check("single_rsp_data", rsp_data, 8'hA5);
        check("single_rsp_last", rsp_last, 1);
        wait_idle();

        // Burst write with wrap from 14 to 1
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
        push_wr(4'd14, 8'h11); push_wr(4'd15, 8'h22);
        push_wr(4'd0, 8'h33);  push_wr(4'd1, 8'h44);
        issue(1'b1, 4'd14, 4'd3);
        for (int i = 0; i < 4; i++) write_beat(wdat[i], 1'b0);
        wait_idle();
        check("mem0_wrap", mem[0], 8'h33);
        check("mem1_wrap", mem[1], 8'h44);
        push_rd(8'h11, 1'b0); push_rd(8'h22, 1'b0);
        push_rd(8'h33, 1'b0); push_rd(8'h44, 1'b1);
        issue(1'b0, 4'd14, 4'd3);
        wait_idle();

        // Backpressure on beat 2 of a 3-beat read
        push_rd(8'h11, 1'b0); push_rd(8'h22, 1'b0); push_rd(8'h33, 1'b1);
        issue(1'b0, 4'd14, 4'd2);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        tick();
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 8'h22);
            check("bp_rsp_last", rsp_last, 0);
            check("bp_ram_addr", ram_addr, 4'd15);
            tick();
        end
        rsp_ready = 1'b1;
        wait_idle();

        // Stalled write burst abandoned by reset after three beats
        push_wr(4'd2, 8'h01); push_wr(4'd3, 8'h02); push_wr(4'd4, 8'h03);
        issue(1'b1, 4'd2, 4'd7);
        write_beat(8'h01, 1'b1);
        write_beat(8'h02, 1'b1);
        write_beat(8'h03, 1'b1);
        rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE;
        #1;
        check("rst_ram_we_forced", ram_we, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_wr_ready", wr_ready, 0);
        tick(); tick(); tick();
        wr_valid = 1'b0;
        push_rd(8'h01, 1'b0); push_rd(8'h02, 1'b0);
        push_rd(8'h03, 1'b0); push_rd(8'h00, 1'b1);
        issue(1'b0, 4'd2, 4'd3);
        wait_idle();

        // Request crossing the top of the RAM
`ifdef RAM_MASTER_BOUNDS_EN
        issue(1'b1, 4'd14, 4'd3);
        check("bounds_req_err", req_err, 1);
        check("bounds_busy", busy, 0);
        check("bounds_wr_ready", wr_ready, 0);
        wr_valid = 1'b1; wr_data = 8'h55;
        tick();
        check("bounds_req_err_clear", req_err, 0);
        tick(); tick();
        wr_valid = 1'b0;
        check("bounds_mem14", mem[14], 8'h11);
        check("bounds_mem0", mem[0], 8'h33);
`else
        push_wr(4'd14, 8'h55); push_wr(4'd15, 8'h66);
        push_wr(4'd0, 8'h77);  push_wr(4'd1, 8'h88);
        issue(1'b1, 4'd14, 4'd3);
        check("nobounds_req_err", req_err, 0);
        write_beat(8'h55, 1'b0); write_beat(8'h66, 1'b0);
        write_beat(8'h77, 1'b0); write_beat(8'h88, 1'b0);
        wait_idle();
        check("nobounds_mem1", mem[1], 8'h88);
`endif
        tick(); tick();

        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_rd_drained", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator-side controller for the team's single-port synchronous RAM (clk/we/addr/din/dout).
- Accepts burst read/write commands over a valid/ready request channel.
- Streams write data in and read data out, and sequences the RAM's we/addr/din pins.
- Sits between any client (DMA, CPU bridge, test driver) and one ram instance.

Parameters:
AW, 4, RAM address width (depth 2^AW)
DW, 8, RAM data width
RD_LAT, 1, RAM read latency: cycles from the clock edge that samples ram_addr to ram_dout valid; must be >= 1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when valid&ready
req_we  input  1  1=write burst, 0=read burst
req_addr  input  AW  burst start address
req_len  input  4  beats minus one (0..15 = 1..16 beats)
wr_valid  input  1  write beat valid
wr_ready  output  1  write beat accepted
wr_data  input  DW  write beat data
rsp_valid  output  1  read beat valid
rsp_ready  input  1  read beat consumed
rsp_data  output  DW  read beat data
rsp_last  output  1  final read beat of the burst
req_err  output  1  one-cycle error pulse (optional feature only)
busy  output  1  burst in progress (state != IDLE)
ram_we  output  1  to RAM we
ram_addr  output  AW  to RAM addr
ram_din  output  DW  to RAM din
ram_dout  input  DW  from RAM dout

Behaviour:
- Reset, synchronous on rising clk with rst_n low:
  - state=IDLE; address counter and beat counter = 0.
  - rsp_valid=0, rsp_data=0, rsp_last=0, req_err=0, busy=0.
- ram_we is forced to 0 in any cycle where rst_n=0.
- Reset mid-burst abandons the burst; no further RAM writes; the client must re-issue.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RSP.
- IDLE:
  - req_ready=1.
  - On accept: addr_q<=req_addr, cnt_q<=req_len; next state is WR if req_we=1, else RD_ISSUE.
- WR:
  - wr_ready=1.
  - ram_we = wr_valid (combinational); ram_addr=addr_q; ram_din=wr_data.
  - The RAM is written at the same edge the beat is accepted.
  - On each accepted beat: addr_q++; if cnt_q==0 go to IDLE, else cnt_q--.
  - wr_valid=0 stalls with no RAM write.
- RD_ISSUE:
  - ram_addr=addr_q, ram_we=0 for one cycle; then RD_WAIT with wait counter=RD_LAT-1.
- RD_WAIT:
  - ram_addr held at addr_q.
  - Decrement the wait counter each cycle.
  - At the edge ending the cycle where the counter is 0: rsp_data<=ram_dout, rsp_valid<=1, rsp_last<=(cnt_q==0); go to RD_RSP.
- RD_RSP:
  - rsp_valid, rsp_data and rsp_last are held stable until rsp_ready=1.
  - On handshake: rsp_valid<=0; if last go to IDLE, else addr_q++, cnt_q--, go to RD_ISSUE.
- Read throughput is one beat per RD_LAT+2 cycles minimum.
- req_ready=0, wr_ready=0 and rsp_valid=0 outside their respective states.
- Address arithmetic is modulo 2^AW: a burst at addr 2^AW-1 wraps to 0.
- A back-to-back request is accepted the cycle after returning to IDLE (one-cycle bubble).
- Outputs ram_we/ram_din are don't-care-free: ram_we=0 and ram_din=0 in every state except WR.

Optional Feature:
- Macro RAM_MASTER_BOUNDS_EN.
- Defined:
  - A request with req_addr+req_len > 2^AW-1 is accepted (req_ready=1) but not executed.
  - req_err pulses high for exactly the cycle after acceptance; state stays IDLE.
  - No RAM access occurs, and wr_ready stays 0 (the client drops its write data).
- Undefined: req_err is tied to 0 and addresses wrap as above.

Decomposition:
- Package ram_master_pkg holds:
  - typedef state_e {IDLE, WR, RD_ISSUE, RD_WAIT, RD_RSP};
  - localparam LEN_W=4;
  - a function for the bounds check.
- No sub-module; single FSM with counters.
- Instantiate alongside the existing ram in the bench for end-to-end checking.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with req_valid=1 -> req_ready/rsp_valid/ram_we/busy all 0; after release req_ready=1.
- Single write/read: write len=0, addr=4, data 8'hA5, then read len=0, addr=4 -> RAM[4]=8'hA5, rsp_data=8'hA5 with rsp_last=1, rsp_valid exactly RD_LAT+1 cycles after the RD_ISSUE cycle.
- Burst with wrap: write len=3 at addr 14 with data 11,22,33,44 -> RAM[14],[15],[0],[1] written; read back in order, rsp_last only on beat 4.
- Backpressure: read len=2 with rsp_ready low for 5 cycles on beat 2 -> rsp_data stable, no extra ram_addr advance, no lost or duplicated beats.
- Write stall and mid-burst reset: write len=7, wr_valid toggling, rst_n=0 after beat 3 -> exactly 3 RAM writes, then IDLE, later beats absent.
- RAM_MASTER_BOUNDS_EN: request addr=14, len=3 -> req_err one-cycle pulse, RAM unchanged, busy=0; without the macro the same request wraps.
